// File: rtl/i2c_frame_parser.sv
// i2c_frame_parser: turns bus-tap line-event tokens into bytes plus ACK bit,
// tracks the address byte of each frame and flags truncated bytes.
module i2c_frame_parser #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [2:0] tap_data,
  input  logic       tap_valid,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_first,
  output logic       byte_ack,
  output logic       addr_hit,
  output logic       frame_rw,
  output logic       frame_start,
  output logic       frame_stop,
  output logic       frame_err
);

  localparam logic [2:0] TOK_START = 3'd1;
  localparam logic [2:0] TOK_BIT1  = 3'd2;
  localparam logic [2:0] TOK_BIT0  = 3'd3;
  localparam logic [2:0] TOK_STOP  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        first_q, first_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        byte_first_q, byte_first_d;
  logic        byte_ack_q, byte_ack_d;
  logic        addr_hit_q, addr_hit_d;
  logic        frame_rw_q, frame_rw_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_stop_q, frame_stop_d;
  logic        frame_err_q, frame_err_d;

  logic        is_bit;
  logic        bit_val;
  logic        partial;

  // Token decode helpers and the "byte in progress" condition used by START/STOP
  always_comb begin
    is_bit  = (tap_data == TOK_BIT1) || (tap_data == TOK_BIT0);
    bit_val = (tap_data == TOK_BIT1);
    partial = (bit_cnt_q != 3'd0) || (state_q == ST_ACK);
  end

  // Next-state and output logic; pulses default low, everything else holds
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    first_d       = first_q;
    byte_data_d   = byte_data_q;
    byte_first_d  = byte_first_q;
    byte_ack_d    = byte_ack_q;
    addr_hit_d    = addr_hit_q;
    frame_rw_d    = frame_rw_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_stop_d  = 1'b0;
    frame_err_d   = 1'b0;

    if (tap_valid) begin
      if (tap_data == TOK_START) begin
        // START (or repeated START) always opens a fresh frame; a partial
        // byte in flight is dropped and reported as an error
        frame_err_d   = (state_q != ST_IDLE) && partial;
        frame_start_d = 1'b1;
        addr_hit_d    = 1'b0;
        frame_rw_d    = 1'b0;
        first_d       = 1'b1;
        bit_cnt_d     = 3'd0;
        shreg_d       = 8'h00;
        state_d       = ST_DATA;
      end else if (tap_data == TOK_STOP) begin
        if (state_q != ST_IDLE) begin
          frame_err_d  = partial;
          frame_stop_d = 1'b1;
          addr_hit_d   = 1'b0;
          frame_rw_d   = 1'b0;
          bit_cnt_d    = 3'd0;
          shreg_d      = 8'h00;
          state_d      = ST_IDLE;
        end
      end else if (is_bit) begin
        if (state_q == ST_DATA) begin
          shreg_d   = {shreg_q[6:0], bit_val};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_ACK;
          end
        end else if (state_q == ST_ACK) begin
          // Ninth bit: report the byte; a NACK keeps the frame open
          byte_valid_d = 1'b1;
          byte_data_d  = shreg_q;
          byte_first_d = first_q;
          byte_ack_d   = ~bit_val;
          if (first_q) begin
            addr_hit_d = (shreg_q[7:1] == SLAVE_ADDR);
            frame_rw_d = shreg_q[0];
          end
          first_d   = 1'b0;
          bit_cnt_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      shreg_q       <= 8'h00;
      bit_cnt_q     <= 3'd0;
      first_q       <= 1'b0;
      byte_data_q   <= 8'h00;
      byte_valid_q  <= 1'b0;
      byte_first_q  <= 1'b0;
      byte_ack_q    <= 1'b0;
      addr_hit_q    <= 1'b0;
      frame_rw_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_stop_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      first_q       <= first_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      byte_first_q  <= byte_first_d;
      byte_ack_q    <= byte_ack_d;
      addr_hit_q    <= addr_hit_d;
      frame_rw_q    <= frame_rw_d;
      frame_start_q <= frame_start_d;
      frame_stop_q  <= frame_stop_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign byte_first  = byte_first_q;
  assign byte_ack    = byte_ack_q;
  assign addr_hit    = addr_hit_q;
  assign frame_rw    = frame_rw_q;
  assign frame_start = frame_start_q;
  assign frame_stop  = frame_stop_q;
  assign frame_err   = frame_err_q;

endmodule

// File: doc/i2c_frame_parser.md
# i2c_frame_parser

Byte-level I2C frame parser sitting directly downstream of the bus tap stage. It consumes the tap's 3-bit line-event tokens (START, BIT1, BIT0, STOP) and assembles 8-bit bytes plus their ACK bit. For each completed byte it reports whether it is the address byte, whether it was ACKed, and whether the address matches this node. It also flags protocol violations such as truncated bytes and mid-byte START/STOP.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address compared against the first byte of each frame.
- `clock`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tap_data`  in  3  token: 1=START, 2=BIT1, 3=BIT0, 4=STOP; 0 and 5..7 are invalid.
- `tap_valid`  in  1  token qualifier, one cycle per token; may be high on consecutive cycles.
- `byte_data`  out  8  assembled byte, MSB first.
- `byte_valid`  out  1  one-cycle pulse when byte plus ACK bit is complete.
- `byte_first`  out  1  qualifies `byte_valid`: this is the address byte.
- `byte_ack`  out  1  qualifies `byte_valid`: 1 when the 9th bit was BIT0 (ACK).
- `addr_hit`  out  1  level: `byte_data[7:1]==SLAVE_ADDR` on the latest address byte. Held until the next START/STOP.
- `frame_rw`  out  1  level: bit 0 of the latest address byte. Held until the next START/STOP.
- `frame_start`  out  1  one-cycle pulse on every START, including repeated START.
- `frame_stop`  out  1  one-cycle pulse on every STOP accepted outside IDLE.
- `frame_err`  out  1  one-cycle pulse on a protocol violation.

## Operation
- Only tokens with `tap_valid=1` are processed. Invalid codes (0, 5..7) are ignored: no state change, no output.
- State `IDLE`:
  - START: enter `DATA`, clear `bit_cnt` to 0, set `first` to 1, pulse `frame_start`.
  - BIT and STOP tokens are ignored.
- State `DATA`:
  - BIT1/BIT0: shift 1/0 into `shreg` LSB, old bits move left so the first bit ends at MSB. Increment `bit_cnt` (3-bit).
  - On the 8th bit (`bit_cnt` 7->0 wrap), enter `ACK`.
- State `ACK`:
  - Any BIT token: pulse `byte_valid` with `byte_data=shreg`, `byte_first=first`, `byte_ack=(token==BIT0)`.
  - If `first`: update `addr_hit` and `frame_rw` from `shreg` on the same edge.
  - Then clear `first` and return to `DATA` with `bit_cnt=0`.
  - A NACK does not end the frame; it continues until START or STOP.
- START in `DATA`/`ACK` (repeated start):
  - Pulse `frame_err` if `bit_cnt!=0` or the state is `ACK`.
  - Discard the partial byte (no `byte_valid`).
  - Clear `addr_hit` and `frame_rw`, set `first`=1, `bit_cnt`=0, stay/enter `DATA`, pulse `frame_start`.
- STOP in `DATA`/`ACK`:
  - Same error rule as START, partial byte discarded.
  - Clear `addr_hit` and `frame_rw`, pulse `frame_stop`, enter `IDLE`.
- `frame_err` and `frame_start`/`frame_stop` may pulse in the same cycle.

## Timing
- All outputs are registered. Every response appears exactly 1 cycle after the `tap_valid` cycle that caused it.
- Pulses (`byte_valid`, `frame_start`, `frame_stop`, `frame_err`) are high for exactly one cycle. There is no backpressure.
- Back-to-back tokens on every cycle are fully supported. No token is dropped at any rate.
- Reset values: all outputs 0, state `IDLE`, `shreg`=0, `bit_cnt`=0, `first`=0.
- Reset asserted mid-frame returns the block immediately to the reset state. The first token after reset is treated as arriving in `IDLE`, so bits are ignored until a START.
- `byte_data`, `byte_first` and `byte_ack` hold their last values between `byte_valid` pulses.

## Test plan
- Address write, one data byte:
  - Stimulus: START, bits 1010000 then 0, BIT0, bits of 0xA5, BIT0, STOP.
  - Response: `frame_start`; `byte_valid` with 0xA0, `byte_first`=1, `byte_ack`=1, `addr_hit`=1, `frame_rw`=0; `byte_valid` with 0xA5, `byte_first`=0, `byte_ack`=1; `frame_stop`; `addr_hit` back to 0.
- Address mismatch and NACK:
  - Stimulus: START, address byte 0x91, BIT1.
  - Response: `byte_valid` 0x91, `byte_ack`=0, `addr_hit`=0, `frame_rw`=1; no `frame_err`.
- Repeated START after 3 data bits:
  - Response: `frame_err` and `frame_start` in the same cycle; no `byte_valid`; the next byte is reported with `byte_first`=1.
- STOP and bits while in IDLE, plus invalid codes 0/5/7 mid-byte:
  - Response: no output pulses; the byte in progress completes correctly.
- Back-to-back stream:
  - Stimulus: 2 full bytes with `tap_valid` high on every cycle.
  - Response: each `byte_valid` fires 1 cycle after its ACK token, with correct data.
- Reset mid-frame:
  - Stimulus: assert `rst_n` low after 5 bits; after release send BIT tokens, then a START.
  - Response: all outputs 0; bits ignored; `frame_start` only on the START.
